// File: rtl/fpu_pkg.sv
// Shared single-precision field widths, integer limits and classify helpers for the FPU datapaths.
package fpu_pkg;

  localparam int F32_EXP_W = 8;
  localparam int F32_MAN_W = 23;
  localparam int F32_BIAS  = 127;

  localparam logic [31:0] INT32_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] INT32_MIN = 32'h8000_0000;

  // Biased exponents that bound the ftoi alignment regions.
  localparam logic [F32_EXP_W-1:0] E_HALF = 8'(F32_BIAS - 1);
  localparam logic [F32_EXP_W-1:0] E_ONE  = 8'(F32_BIAS);
  localparam logic [F32_EXP_W-1:0] E_INT  = 8'(F32_BIAS + F32_MAN_W);
  localparam logic [F32_EXP_W-1:0] E_SAT  = 8'(F32_BIAS + 31);

  typedef struct packed {
    logic                 s;
    logic [F32_EXP_W-1:0] e;
    logic [F32_MAN_W:0]   mant;
    logic                 nan;
    logic                 inf;
    logic                 zero;
  } ftoi_s1_t;

  typedef struct packed {
    logic        s;
    logic [31:0] mag;
    logic        guard;
    logic        sat;
    logic        nan;
  } ftoi_s2_t;

  function automatic logic f32_is_nan(input logic [31:0] f);
    return (f[30:23] == 8'hFF) && (f[22:0] != 23'd0);
  endfunction

  function automatic logic f32_is_inf(input logic [31:0] f);
    return (f[30:23] == 8'hFF) && (f[22:0] == 23'd0);
  endfunction

endpackage

// File: rtl/ftoi_round.sv
// Final ftoi stage: round the aligned magnitude, apply the sign and saturate specials.
module ftoi_round
  import fpu_pkg::*;
#(
  parameter bit ROUND_NEAREST = 1'b1
) (
  input  logic        s_i,
  input  logic [31:0] mag_i,
  input  logic        guard_i,
  input  logic        sat_i,
  input  logic        nan_i,
  output logic [31:0] y_o,
  output logic        ovf_o
);

  logic [31:0] r_s;

  // Round, negate, or saturate; NaN always saturates to the positive limit.
  always_comb begin
    r_s   = mag_i + ((ROUND_NEAREST && guard_i) ? 32'd1 : 32'd0);
    y_o   = 32'd0;
    ovf_o = 1'b0;
    if (sat_i) begin
      y_o   = (nan_i || !s_i) ? INT32_MAX : INT32_MIN;
      ovf_o = 1'b1;
    end else begin
      y_o   = s_i ? (32'd0 - r_s) : r_s;
      ovf_o = 1'b0;
    end
  end

endmodule

// File: rtl/ftoi_pipe.sv
// Three-stage float32 -> int32 converter (unpack, align, round) with a valid/ready stream on both sides.
module ftoi_pipe
  import fpu_pkg::*;
#(
  parameter bit ROUND_NEAREST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y,
  output logic        ovf
);

  logic        v1_q, v2_q, v3_q;
  logic        load1_s, load2_s, load3_s;
  ftoi_s1_t    s1_q, s1_d;
  ftoi_s2_t    s2_q, s2_d;
  logic [31:0] y_q, y_d;
  logic        ovf_q, ovf_d;
  logic [3:0]  lsh_s;
  logic [4:0]  rsh_s;

  // Ready chain: a stage may load when empty or when the stage after it is loading.
  always_comb begin
    load3_s = !v3_q || out_ready;
    load2_s = !v2_q || load3_s;
    load1_s = !v1_q || load2_s;
  end

  assign in_ready  = load1_s;
  assign out_valid = v3_q;
  assign y         = y_q;
  assign ovf       = ovf_q;

  // S1 unpack and classify.
  always_comb begin
    s1_d.s    = x[31];
    s1_d.e    = x[30:23];
    s1_d.mant = {1'b1, x[22:0]};
    s1_d.nan  = f32_is_nan(x);
    s1_d.inf  = f32_is_inf(x);
    s1_d.zero = (x[30:23] == 8'd0);
  end

  // S2 align: left shift for large exponents, right shift with guard bit otherwise.
  always_comb begin
    s2_d.s     = s1_q.s;
    s2_d.nan   = s1_q.nan;
    s2_d.mag   = 32'd0;
    s2_d.guard = 1'b0;
    lsh_s      = 4'(s1_q.e - E_INT);
    rsh_s      = 5'(E_INT - s1_q.e);
    // -2^31 exactly lands on e == E_SAT but is representable, so it is carved out.
    s2_d.sat   = s1_q.nan || s1_q.inf ||
                 ((s1_q.e >= E_SAT) && !(s1_q.s && (s1_q.e == E_SAT) && (s1_q.mant == 24'h80_0000)));
    if (s1_q.zero) begin
      s2_d.mag   = 32'd0;
      s2_d.guard = 1'b0;
    end else if (s1_q.e >= E_INT) begin
      if (s1_q.e <= E_SAT) begin
        s2_d.mag = {8'd0, s1_q.mant} << lsh_s;
      end else begin
        s2_d.mag = 32'd0;
      end
    end else if (s1_q.e >= E_ONE) begin
      s2_d.mag   = {8'd0, s1_q.mant} >> rsh_s;
      s2_d.guard = s1_q.mant[rsh_s - 5'd1];
    end else if (s1_q.e == E_HALF) begin
      s2_d.mag   = 32'd0;
      s2_d.guard = 1'b1;
    end else begin
      s2_d.mag   = 32'd0;
      s2_d.guard = 1'b0;
    end
  end

  ftoi_round #(
    .ROUND_NEAREST(ROUND_NEAREST)
  ) u_round (
    .s_i    (s2_q.s),
    .mag_i  (s2_q.mag),
    .guard_i(s2_q.guard),
    .sat_i  (s2_q.sat),
    .nan_i  (s2_q.nan),
    .y_o    (y_d),
    .ovf_o  (ovf_d)
  );

  // Stage registers; each stage holds its contents while the next one stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      s1_q  <= '0;
      s2_q  <= '0;
      y_q   <= 32'd0;
      ovf_q <= 1'b0;
    end else begin
      if (load1_s) begin
        v1_q <= in_valid;
        s1_q <= s1_d;
      end
      if (load2_s) begin
        v2_q <= v1_q;
        s2_q <= s2_d;
      end
      if (load3_s) begin
        v3_q  <= v2_q;
        y_q   <= y_d;
        ovf_q <= ovf_d;
      end
    end
  end

endmodule

// File: tb/tb_ftoi_pipe.sv
// Bench for ftoi_pipe: two instances (nearest / truncate) share one stream, checked against a value-based model.
module tb_ftoi_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] x;
  logic        in_ready, out_valid, ovf;
  logic [31:0] y;
  logic        in_ready_t, out_valid_t, ovf_t;
  logic [31:0] y_t;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] y1;
    logic        o1;
    logic [31:0] y0;
    logic        o0;
    int          acc;
  } exp_t;

  exp_t        q[$];
  bit          chk_lat;
  bit          hold_v;
  logic [31:0] hold_y, hold_yt;
  logic        hold_o;

  localparam longint IMAX = 64'sd2147483647;
  localparam longint IMIN = -64'sd2147483648;

  ftoi_pipe #(.ROUND_NEAREST(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x(x),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .ovf(ovf)
  );

  ftoi_pipe #(.ROUND_NEAREST(1'b0)) dut_t (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_t), .x(x),
    .out_valid(out_valid_t), .out_ready(out_ready), .y(y_t), .ovf(ovf_t)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Value model: exact real value mant * 2^(e-150), rounded, then range-checked as a signed integer.
  function automatic void model(input logic [31:0] f, input bit rn,
                                output logic [31:0] yy, output logic oo);
    int     e;
    int     k;
    longint mant, mag, val;
    e    = int'(f[30:23]);
    mant = longint'({1'b1, f[22:0]});
    oo   = 1'b0;
    yy   = 32'd0;
    if (e == 0) return;
    if (e == 255) begin
      oo = 1'b1;
      yy = ((f[22:0] != 23'd0) || !f[31]) ? 32'h7FFF_FFFF : 32'h8000_0000;
      return;
    end
    if (e >= 180) mag = 64'sh0000_7FFF_FFFF_FFFF;
    else if (e >= 150) mag = mant <<< (e - 150);
    else begin
      k = 150 - e;
      if (k > 40) mag = 0;
      else if (rn) mag = (mant + (64'sd1 <<< (k - 1))) >>> k;
      else mag = mant >>> k;
    end
    val = f[31] ? -mag : mag;
    if (val > IMAX || val < IMIN) begin
      oo = 1'b1;
      yy = f[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else begin
      yy = val[31:0];
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One cycle: drive at the negedge, check mid-cycle, advance to the next negedge.
  task automatic step(input logic iv, input logic [31:0] ix, input logic ordy, input bit dir,
                      input logic [31:0] dy1, input logic do1, input logic [31:0] dy0, input logic do0);
    exp_t ex;
    in_valid  = iv;
    x         = ix;
    out_ready = ordy;
    #1;
    chk("in_ready", {31'd0, in_ready}, {31'd0, (q.size() < 3) || ordy});
    chk("in_ready_t", {31'd0, in_ready_t}, {31'd0, (q.size() < 3) || ordy});
    if (hold_v) begin
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_y", y, hold_y);
      chk("hold_ovf", {31'd0, ovf}, {31'd0, hold_o});
      chk("hold_y_t", y_t, hold_yt);
    end
    if (out_valid && ordy) begin
      if (q.size() == 0) begin
        chk("spurious_out", {31'd0, out_valid}, 32'd0);
      end else begin
        ex = q.pop_front();
        chk("y_rn", y, ex.y1);
        chk("ovf_rn", {31'd0, ovf}, {31'd0, ex.o1});
        chk("valid_tr", {31'd0, out_valid_t}, 32'd1);
        chk("y_tr", y_t, ex.y0);
        chk("ovf_tr", {31'd0, ovf_t}, {31'd0, ex.o0});
        if (chk_lat) chk("latency", 32'(cyc - ex.acc), 32'd3);
      end
    end
    if (iv && in_ready) begin
      if (dir) begin
        ex.y1 = dy1; ex.o1 = do1; ex.y0 = dy0; ex.o0 = do0;
      end else begin
        model(ix, 1'b1, ex.y1, ex.o1);
        model(ix, 1'b0, ex.y0, ex.o0);
      end
      ex.acc = cyc;
      q.push_back(ex);
    end
    hold_v  = out_valid && !ordy;
    hold_y  = y;
    hold_yt = y_t;
    hold_o  = ovf;
    @(negedge clk);
  endtask

  task automatic send(input logic [31:0] ix, input logic ordy);
    step(1'b1, ix, ordy, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 32'd0, ordy, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
  endtask

  function automatic logic [31:0] rand_f();
    logic [31:0] f;
    f = $urandom;
    if ($urandom_range(3, 0) != 0) f[30:23] = 8'($urandom_range(160, 120));
    return f;
  endfunction

  localparam int ND = 14;
  logic [31:0] d_x  [ND] = '{32'h3FC00000, 32'hC0200000, 32'h3EFFFFFF, 32'h3F000000, 32'h4EFFFFFF,
                             32'h4F000000, 32'hCF000000, 32'h7FC00000, 32'hC0700000, 32'h3F7FFFFF,
                             32'h80000000, 32'hFF800000, 32'hBF000000, 32'hBEFFFFFF};
  logic [31:0] d_y1 [ND] = '{32'h00000002, 32'hFFFFFFFD, 32'h00000000, 32'h00000001, 32'h7FFFFF80,
                             32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFC, 32'h00000001,
                             32'h00000000, 32'h80000000, 32'hFFFFFFFF, 32'h00000000};
  logic [31:0] d_y0 [ND] = '{32'h00000001, 32'hFFFFFFFE, 32'h00000000, 32'h00000000, 32'h7FFFFF80,
                             32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFD, 32'h00000000,
                             32'h00000000, 32'h80000000, 32'h00000000, 32'h00000000};
  logic        d_o  [ND] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0,
                             1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x         = 32'd0;
    chk_lat   = 1'b0;
    hold_v    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_y", y, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    rst = 1'b0;

    // Directed rounding, range edges and specials.
    for (int i = 0; i < ND; i++) step(1'b1, d_x[i], 1'b1, 1'b1, d_y1[i], d_o[i], d_y0[i], d_o[i]);
    for (int i = 0; i < 4; i++) idle(1'b1);

    // Back-to-back stream with latency check.
    chk_lat = 1'b1;
    for (int i = 0; i < 8; i++) send(rand_f(), 1'b1);
    for (int i = 0; i < 4; i++) idle(1'b1);
    chk_lat = 1'b0;

    // Backpressure: five stalled cycles, then drain.
    for (int i = 0; i < 5; i++) send(rand_f(), 1'b0);
    chk("bp_fill", 32'(q.size()), 32'd3);
    for (int i = 0; i < 4; i++) idle(1'b1);

    // Reset with three operands in flight.
    for (int i = 0; i < 3; i++) send(rand_f(), 1'b0);
    rst = 1'b1;
    idle(1'b0);
    rst = 1'b0;
    q.delete();
    hold_v = 1'b0;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_y", y, 32'd0);
    chk("mid_rst_ovf", {31'd0, ovf}, 32'd0);
    for (int i = 0; i < 6; i++) idle(1'b1);

    // Random traffic with random backpressure.
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(1, 0)), rand_f(), 1'($urandom_range(3, 0) != 0), 1'b0,
           32'd0, 1'b0, 32'd0, 1'b0);
    end
    for (int i = 0; i < 20 && q.size() != 0; i++) idle(1'b1);
    chk("drained", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
